// File: rtl/mem_access_seq_pkg.sv
// Shared definitions for the load/store sequencer.
// Holds the FSM state encoding, the request size codes, the byte-offset
// codes and the small helper functions used to derive lane masks and
// extend load results.
package mem_access_seq_pkg;

  // Sequencer states: one LO word access always, an HI word access only
  // when the request straddles a word boundary.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Request size codes; 2'b11 behaves exactly like a word.
  localparam logic [1:0] SIZE_BYTE     = 2'b00;
  localparam logic [1:0] SIZE_HALF     = 2'b01;
  localparam logic [1:0] SIZE_WORD     = 2'b10;
  localparam logic [1:0] SIZE_WORD_ALT = 2'b11;

  // Byte offset of the request inside its first word.
  localparam logic [1:0] OFF_0 = 2'b00;
  localparam logic [1:0] OFF_1 = 2'b01;
  localparam logic [1:0] OFF_2 = 2'b10;
  localparam logic [1:0] OFF_3 = 2'b11;

  // Byte mask of an aligned access of the given size (bit i = byte i).
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001;
      SIZE_HALF: mask = 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Lanes touched across two consecutive words: bits [3:0] are the LO word
  // lanes, bits [7:4] the HI word lanes. Any HI bit means a crossing access.
  function automatic logic [7:0] lane_span(input logic [3:0] mask, input logic [1:0] off);
    return {4'b0000, mask} << off;
  endfunction

  // Sign- or zero-extend an LSB-justified load result to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] res;
    case (size)
      SIZE_BYTE: res = {{24{~uns & data[7]}}, data[7:0]};
      SIZE_HALF: res = {{16{~uns & data[15]}}, data[15:0]};
      default:   res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Bus bundle between the core, the sequencer and the four byte banks.
//   req_*  : core load/store request (valid/ready handshake)
//   rsp_*  : one-cycle completion pulse with load data
//   mem_*  : shared word address, read strobe, per-bank write enables,
//            lane-arranged write data, lane offset, bank read data
// Modport slave is the sequencer; master is the environment (core plus
// the bank array, which returns mem_rdata).
interface mem_access_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_lane_off;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata,
    output mem_addr, mem_re, mem_be, mem_wdata, mem_lane_off,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    input  mem_addr, mem_re, mem_be, mem_wdata, mem_lane_off,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_seq_lane_rot.sv
// mem_lane_rot: combinational byte-lane rotator.
//   din  : 32-bit input word
//   off  : rotate amount in bytes
//   dout : rotated word
// LEFT=1 moves byte i to lane (i+off) mod 4 (store path);
// LEFT=0 moves lane (i+off) mod 4 to byte i (load path).
module mem_lane_rot #(
  parameter bit LEFT = 1'b1
) (
  input  logic [31:0] din,
  input  logic [1:0]  off,
  output logic [31:0] dout
);

  logic [1:0] sel;

  // A left rotation by off is a right rotation by (4 - off) mod 4.
  assign sel = LEFT ? (2'b00 - off) : off;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [1:0] src;
    assign src = 2'(i) + sel;
    assign dout[8*i +: 8] = din[{src, 3'b000} +: 8];
  end

endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences byte/half/word loads and stores of any
// alignment onto four byte-wide banks sharing one word address.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : request, response and bank signals (slave modport)
// A request occupies LO (first word), optionally HI (next word, when it
// straddles a boundary), then DONE, which pulses rsp_valid.
module mem_access_seq
  import mem_access_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_access_seq_if.slave   bus
);

  state_t      state_r;
  state_t      state_nxt_s;

  logic        we_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic [1:0]  off_r;
  logic [29:0] word_r;
  logic [31:0] wdata_r;
  logic [31:0] cap_r;

  logic        accept_s;
  logic [7:0]  span_s;
  logic        cross_s;
  logic [31:0] st_lanes_s;
  logic [31:0] merged_s;
  logic [31:0] ld_aligned_s;

  assign accept_s = bus.req_valid && (state_r == ST_IDLE);
  assign span_s   = lane_span(size_mask(size_r), off_r);
  assign cross_s  = |span_s[7:4];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request fields are captured only on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      size_r  <= SIZE_BYTE;
      uns_r   <= 1'b0;
      off_r   <= OFF_0;
      word_r  <= 30'h0;
      wdata_r <= 32'h0;
    end else if (accept_s) begin
      we_r    <= bus.req_we;
      size_r  <= bus.req_size;
      uns_r   <= bus.req_unsigned;
      off_r   <= bus.req_addr[1:0];
      word_r  <= bus.req_addr[31:2];
      wdata_r <= bus.req_wdata;
    end
  end

  // The LO word's read data is on mem_rdata during HI; hold it for DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_r <= 32'h0;
    end else if (state_r == ST_HI) begin
      cap_r <= bus.mem_rdata;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt_s = ST_LO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LO: begin
        if (cross_s) begin
          state_nxt_s = ST_HI;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_HI:   state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  mem_lane_rot #(.LEFT(1'b1)) u_rot_store (
    .din  (wdata_r),
    .off  (off_r),
    .dout (st_lanes_s)
  );

  // In DONE of a crossing load, the LO-word lanes come from the captured
  // copy and the HI-word lanes from the live bank data.
  for (genvar j = 0; j < 4; j++) begin : g_merge
    assign merged_s[8*j +: 8] = (cross_s && span_s[j]) ? cap_r[8*j +: 8]
                                                        : bus.mem_rdata[8*j +: 8];
  end

  mem_lane_rot #(.LEFT(1'b0)) u_rot_load (
    .din  (merged_s),
    .off  (off_r),
    .dout (ld_aligned_s)
  );

  // Outputs decoded from the current state and the captured request.
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = 32'h0;
    bus.mem_addr     = 30'h0;
    bus.mem_re       = 1'b0;
    bus.mem_be       = 4'h0;
    bus.mem_wdata    = 32'h0;
    bus.mem_lane_off = OFF_0;
    case (state_r)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
      end
      ST_LO: begin
        bus.mem_addr     = word_r;
        bus.mem_lane_off = off_r;
        if (we_r) begin
          bus.mem_be    = span_s[3:0];
          bus.mem_wdata = st_lanes_s;
        end else begin
          bus.mem_re    = 1'b1;
        end
      end
      ST_HI: begin
        bus.mem_addr     = word_r + 30'd1;
        bus.mem_lane_off = off_r;
        if (we_r) begin
          bus.mem_be    = span_s[7:4];
          bus.mem_wdata = st_lanes_s;
        end else begin
          bus.mem_re    = 1'b1;
        end
      end
      ST_DONE: begin
        bus.rsp_valid = 1'b1;
        if (we_r) begin
          bus.rsp_rdata = 32'h0;
        end else begin
          bus.rsp_rdata = load_extend(ld_aligned_s, size_r, uns_r);
        end
      end
      default: begin
        bus.req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_seq.sv
module tb_mem_access_seq;

  logic clk;
  logic rst;
  logic mem_init;
  int   cyc;
  int   errors;
  int   checks;

  mem_access_seq_if bus ();

  mem_access_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bank array environment (128 words, low address bits) ----
  logic [31:0] bank_mem [128];
  logic [31:0] rd_q;

  function automatic logic [7:0] init_byte(input logic [8:0] b);
    return 8'(b * 9'd37 + 9'd11);
  endfunction

  function automatic logic [31:0] init_word(input logic [6:0] k);
    logic [31:0] w;
    for (int l = 0; l < 4; l++) w[8*l +: 8] = init_byte({k, 2'(l)});
    return w;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 128; k++) bank_mem[k] <= init_word(7'(k));
    end else begin
      if (bus.mem_re) rd_q <= bank_mem[bus.mem_addr[6:0]];
      if (bus.mem_be != 4'h0)
        bank_mem[bus.mem_addr[6:0]] <= merge_be(bank_mem[bus.mem_addr[6:0]], bus.mem_wdata, bus.mem_be);
    end
  end

  assign bus.mem_rdata = rd_q;

  // ---------------- byte-addressed reference memory ------------------------
  logic [7:0] ref_mem [512];

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    logic [31:0] v, b;
    int n;
    n = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      b = addr + 32'(i);
      v[8*i +: 8] = ref_mem[b[8:0]];
    end
    if (!uns && n == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
    if (!uns && n == 2 && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] b;
    for (int i = 0; i < nbytes(size); i++) begin
      b = addr + 32'(i);
      ref_mem[b[8:0]] = wdata[8*i +: 8];
    end
  endtask

  function automatic int exp_latency(input logic [31:0] addr, input logic [1:0] size);
    return (int'(addr[1:0]) + nbytes(size) > 4) ? 2 : 1;
  endfunction

  // ---------------- checking ----------------------------------------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Per-cycle observations of the most recent do_req, for directed checks.
  logic [29:0] obs_addr  [3];
  logic [3:0]  obs_be    [3];
  logic [31:0] obs_wdata [3];
  logic [31:0] last_rdata;
  int          last_lat;

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  task automatic gen_req(output logic we, output logic [1:0] size, output logic uns,
                         output logic [31:0] addr, output logic [31:0] wdata);
    we    = 1'($urandom_range(0, 1));
    size  = 2'($urandom_range(0, 3));
    uns   = 1'($urandom_range(0, 1));
    wdata = $urandom;
    if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    else                           addr = 32'h0000_00F0 + 32'($urandom_range(0, 79));
  endtask

  // One isolated request with per-cycle bank checks.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          n, ncyc;
    logic [31:0] exp_rd, b, e_wd, mask;
    logic [29:0] wa;
    logic [3:0]  e_be;
    n      = nbytes(size);
    exp_rd = we ? 32'h0 : ref_load(addr, size, uns);
    @(negedge clk);
    check_val("idle_ready", {31'h0, bus.req_ready}, 32'h1);
    drive_req(we, size, uns, addr, wdata);
    @(posedge clk); #1;
    // Garbage with valid still high while busy: must be ignored.
    drive_req(~we, 2'($urandom), ~uns, $urandom, $urandom);
    if (we) ref_store(addr, size, wdata);
    ncyc = 0;
    while (bus.rsp_valid !== 1'b1 && ncyc < 4) begin
      wa = addr[31:2] + 30'(ncyc);
      e_be = 4'h0; e_wd = 32'h0; mask = 32'h0;
      for (int i = 0; i < n; i++) begin
        b = addr + 32'(i);
        if (b[31:2] == wa) begin
          e_be[b[1:0]] = 1'b1;
          e_wd[8*int'(b[1:0]) +: 8] = wdata[8*i +: 8];
          mask[8*int'(b[1:0]) +: 8] = 8'hFF;
        end
      end
      if (ncyc < 3) begin
        obs_addr[ncyc]  = bus.mem_addr;
        obs_be[ncyc]    = bus.mem_be;
        obs_wdata[ncyc] = bus.mem_wdata;
      end
      check_val("mem_addr", {2'b00, bus.mem_addr}, {2'b00, wa});
      check_val("mem_lane_off", {30'h0, bus.mem_lane_off}, {30'h0, addr[1:0]});
      if (we) begin
        check_val("st_mem_be", {28'h0, bus.mem_be}, {28'h0, e_be});
        check_val("st_mem_wdata", bus.mem_wdata & mask, e_wd);
        check_val("st_mem_re", {31'h0, bus.mem_re}, 32'h0);
      end else begin
        check_val("ld_mem_re", {31'h0, bus.mem_re}, 32'h1);
        check_val("ld_mem_be", {28'h0, bus.mem_be}, 32'h0);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      ncyc++;
    end
    last_lat   = ncyc;
    last_rdata = bus.rsp_rdata;
    check_val("latency", ncyc, exp_latency(addr, size));
    check_val("rsp_rdata", bus.rsp_rdata, exp_rd);
    check_val("done_quiet", {27'h0, bus.mem_be, bus.mem_re}, 32'h0);
    @(posedge clk); #1;
    check_val("rsp_one_pulse", {31'h0, bus.rsp_valid}, 32'h0);
    check_val("back_to_idle", {31'h0, bus.req_ready}, 32'h1);
  endtask

  // req_valid held high across many requests; responses checked in order.
  typedef struct { logic [31:0] rdata; int lat; int acc; } exp_t;

  task automatic run_stream(input int nreq);
    exp_t        q[$];
    exp_t        e;
    int          idx, nrsp;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    idx = 0; nrsp = 0;
    gen_req(we, size, uns, addr, wdata);
    @(negedge clk);
    drive_req(we, size, uns, addr, wdata);
    for (int t = 0; t < nreq * 6 + 20; t++) begin
      if (bus.rsp_valid === 1'b1) begin
        nrsp++;
        if (q.size() > 0) begin
          e = q.pop_front();
          check_val("stream_rdata", bus.rsp_rdata, e.rdata);
          check_val("stream_latency", cyc - e.acc, e.lat);
        end
      end
      if (idx < nreq && bus.req_ready === 1'b1) begin
        e.rdata = we ? 32'h0 : ref_load(addr, size, uns);
        e.lat   = exp_latency(addr, size);
        e.acc   = cyc + 1;
        q.push_back(e);
        if (we) ref_store(addr, size, wdata);
        idx++;
        if (idx < nreq) gen_req(we, size, uns, addr, wdata);
        @(posedge clk); #1;
        if (idx < nreq) drive_req(we, size, uns, addr, wdata);
        else            bus.req_valid = 1'b0;
      end
      if (idx == nreq && q.size() == 0) break;
      @(negedge clk);
    end
    check_val("stream_accepts", idx, nreq);
    check_val("stream_responses", nrsp, nreq);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    errors = 0; checks = 0;
    for (int b = 0; b < 512; b++) ref_mem[b] = init_byte(9'(b));
    rst = 1'b1; mem_init = 1'b1;
    drive_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check_val("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check_val("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_val("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_val("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    check_val("rst_mem_re", {31'h0, bus.mem_re}, 32'h0);
    check_val("rst_mem_addr", {2'b00, bus.mem_addr}, 32'h0);
    check_val("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check_val("rst_lane_off", {30'h0, bus.mem_lane_off}, 32'h0);
    rst = 1'b0;

    // Aligned word store.
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hA1B2_C3D4);
    check_val("d1_lat", last_lat, 1);
    check_val("d1_addr", {2'b00, obs_addr[0]}, 32'h40);
    check_val("d1_be", {28'h0, obs_be[0]}, 32'hF);
    check_val("d1_wdata", obs_wdata[0], 32'hA1B2_C3D4);

    // Byte load of 0x80 at offset 3, signed then unsigned.
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_0080);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
    check_val("d2_addr", {2'b00, obs_addr[0]}, 32'h40);
    check_val("d2_signed", last_rdata, 32'hFFFF_FF80);
    check_val("d2_lat", last_lat, 1);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
    check_val("d2_unsigned", last_rdata, 32'h0000_0080);

    // Crossing word store.
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1122_3344);
    check_val("d3_lat", last_lat, 2);
    check_val("d3_lo_addr", {2'b00, obs_addr[0]}, 32'h40);
    check_val("d3_lo_be", {28'h0, obs_be[0]}, 32'hC);
    check_val("d3_lo_lanes", {16'h0, obs_wdata[0][31:16]}, 32'h3344);
    check_val("d3_hi_addr", {2'b00, obs_addr[1]}, 32'h41);
    check_val("d3_hi_be", {28'h0, obs_be[1]}, 32'h3);
    check_val("d3_hi_lanes", {16'h0, obs_wdata[1][15:0]}, 32'h1122);

    // Half load wrapping from the top word to word 0.
    do_req(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0034);
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0012);
    do_req(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0);
    check_val("d4_lo_addr", {2'b00, obs_addr[0]}, 32'h3FFF_FFFF);
    check_val("d4_hi_addr", {2'b00, obs_addr[1]}, 32'h0);
    check_val("d4_rdata", last_rdata, 32'h0000_1234);

    // Reset during HI of a crossing store.
    @(negedge clk);
    drive_req(1'b1, 2'b10, 1'b0, 32'h0000_0106, 32'hCAFE_F00D);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_val("d5_lo_be", {28'h0, bus.mem_be}, 32'hC);
    @(posedge clk); #1;
    check_val("d5_hi_be", {28'h0, bus.mem_be}, 32'h3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("d5_ready", {31'h0, bus.req_ready}, 32'h1);
    check_val("d5_be", {28'h0, bus.mem_be}, 32'h0);
    check_val("d5_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    bad = 0;
    repeat (3) begin
      if (bus.rsp_valid !== 1'b0 || bus.mem_be !== 4'h0) bad++;
      @(posedge clk); #1;
    end
    check_val("d5_no_activity", bad, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0106, 32'h5566_7788);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0106, 32'h0);
    check_val("d5_reload", last_rdata, 32'h5566_7788);

    // Random isolated requests.
    for (int r = 0; r < 60; r++) begin
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      gen_req(we, size, uns, addr, wdata);
      do_req(we, size, uns, addr, wdata);
    end

    // Back-to-back with req_valid held high.
    run_stream(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
